// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM capture block.
//   pwm_cap_state_t : measurement FSM state (IDLE, HIGH, LOW)
//   PWM_CNT_W_DEF   : default width of tick counters and measurement outputs
package pwm_pkg;

    localparam int PWM_CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_cap_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// pwm_in_sync: brings the asynchronous PWM pin into the clk domain and
// derives single-cycle edge strobes from the synchronized level.
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   pwm_in in  asynchronous PWM input
//   level  out synchronized level (second synchronizer flop, s2)
//   rise   out s2 high while the previous s2 was low
//   fall   out s2 low while the previous s2 was high
module pwm_in_sync (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= pwm_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    // rise and fall are mutually exclusive by construction.
    assign level = s2;
    assign rise  = s2 & ~prev;
    assign fall  = ~s2 & prev;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an incoming PWM waveform in
// prescaled clock ticks.
//   clk         in  system clock
//   rst         in  asynchronous active-high reset
//   pwm_in      in  asynchronous PWM input
//   divisor     in  prescale value; one tick every divisor+1 clocks
//   high_time   out ticks the last complete period spent high
//   period      out ticks from one rising edge to the next
//   valid       out one-cycle strobe; high_time/period update in that cycle
//   stuck       out period counter saturated without an edge
//   stuck_level out synchronized input level when stuck was set
//   state_dbg   out current measurement FSM state
//
// Handshake: valid is a pure strobe with no ready/back-pressure. Whenever
// valid is 1, high_time and period carry a fresh measurement in that same
// cycle; they hold their values at all other times.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    input  logic [5:0]       divisor,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             stuck,
    output logic             stuck_level,
    output pwm_cap_state_t   state_dbg
);

    logic level;
    logic rise;
    logic fall;

    pwm_in_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    // Prescaler: tick while the down-counter is zero, then reload. The
    // divisor is only looked at on reload, so a change lands cleanly.
    logic [5:0] pre_cnt;
    logic       tick;

    assign tick = (pre_cnt == 6'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= 6'd0;
        end else if (tick) begin
            pre_cnt <= divisor;
        end else begin
            pre_cnt <= pre_cnt - 6'd1;
        end
    end

    // Measurement FSM
    pwm_cap_state_t   state;
    pwm_cap_state_t   state_nx;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic             per_max;
    logic             hi_max;
    logic             do_valid;
    logic             set_stuck;

    assign per_max = &per_cnt;
    assign hi_max  = &hi_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        do_valid  = 1'b0;
        set_stuck = 1'b0;
        case (state)
            IDLE: begin
                // First rise only arms the measurement.
                if (rise) begin
                    state_nx = HIGH;
                end
            end
            HIGH: begin
                // Saturation wins over a coincident fall: the period is
                // already unmeasurable.
                if (per_max && tick) begin
                    set_stuck = 1'b1;
                    state_nx  = IDLE;
                end else if (fall) begin
                    state_nx = LOW;
                end
            end
            LOW: begin
                // A rise closes the period even if the counter reached
                // all-ones in this very cycle.
                if (rise) begin
                    do_valid = 1'b1;
                    state_nx = HIGH;
                end else if (per_max && tick) begin
                    set_stuck = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Tick counters. A rise restarts both; the rise cycle itself counts as
    // one tick when the prescaler fires in it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (rise) begin
            per_cnt <= {{(CNT_W-1){1'b0}}, tick};
            hi_cnt  <= {{(CNT_W-1){1'b0}}, tick};
        end else begin
            if (state != IDLE && tick && !per_max) begin
                per_cnt <= per_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            // The fall cycle belongs to the low phase.
            if (state == HIGH && !fall && tick && !hi_max) begin
                hi_cnt <= hi_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_time   <= '0;
            period      <= '0;
            valid       <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            valid <= do_valid;
            if (do_valid) begin
                high_time <= hi_cnt;
                period    <= per_cnt;
            end
            // set_stuck never coincides with rise.
            if (set_stuck) begin
                stuck       <= 1'b1;
                stuck_level <= level;
            end else if (rise) begin
                stuck <= 1'b0;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: bench for pwm_capture with a 16-bit and an 8-bit instance
// driven from the same pin.
module tb_pwm_capture;
    import pwm_pkg::*;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       pwm_in = 1'b0;
    logic [5:0] divisor = 6'd0;

    logic [15:0]    hi16, per16;
    logic           val16, stk16, stl16;
    pwm_cap_state_t st16;
    logic [7:0]     hi8, per8;
    logic           val8, stk8, stl8;
    pwm_cap_state_t st8;

    pwm_capture #(.CNT_W(16)) dut16 (
        .clk(clk), .rst(rst), .pwm_in(pwm_in), .divisor(divisor),
        .high_time(hi16), .period(per16), .valid(val16), .stuck(stk16),
        .stuck_level(stl16), .state_dbg(st16)
    );

    pwm_capture #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .pwm_in(pwm_in), .divisor(divisor),
        .high_time(hi8), .period(per8), .valid(val8), .stuck(stk8),
        .stuck_level(stl8), .state_dbg(st8)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: works from the edge times of the sampled pin and
    // counts prescaler ticks between them arithmetically. A tick happens in
    // every cycle whose index since reset release is a multiple of divisor+1.
    bit samp_q[$];
    int cyc_n;
    int val_cnt16;
    int max_v[2] = '{65535, 255};
    bit meas[2];
    bit fseen[2];
    int r1[2], fc[2];
    bit exp_v[2], exp_s[2], exp_sl[2];
    int exp_h[2], exp_p[2];

    function automatic int ticks(input int a, input int b, input int d);
        return (b + d - 1) / d - (a + d - 1) / d;
    endfunction

    function automatic bit samp(input int e);
        if (e >= 1 && e <= samp_q.size()) return samp_q[e-1];
        return 1'b0;
    endfunction

    task automatic check_outputs();
        chk("valid16", val16, exp_v[0]);
        chk("stuck16", stk16, exp_s[0]);
        chk("stuck_level16", stl16, exp_sl[0]);
        chk("high_time16", hi16, exp_h[0]);
        chk("period16", per16, exp_p[0]);
        chk("valid8", val8, exp_v[1]);
        chk("stuck8", stk8, exp_s[1]);
        chk("stuck_level8", stl8, exp_sl[1]);
        chk("high_time8", hi8, exp_h[1]);
        chk("period8", per8, exp_p[1]);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            samp_q.delete();
            cyc_n = 0;
            val_cnt16 = 0;
            for (int i = 0; i < 2; i++) begin
                meas[i] = 0; fseen[i] = 0; r1[i] = 0; fc[i] = 0;
                exp_v[i] = 0; exp_s[i] = 0; exp_sl[i] = 0; exp_h[i] = 0; exp_p[i] = 0;
            end
            check_outputs();
            chk("state16_reset", st16, IDLE);
            chk("state8_reset", st8, IDLE);
        end else begin
            bit lv, pv, rs, fl, tk;
            int d, t;
            check_outputs();
            if (val16 === 1'b1) val_cnt16++;
            d  = int'(divisor) + 1;
            tk = (cyc_n % d) == 0;
            lv = samp(cyc_n - 1);
            pv = samp(cyc_n - 2);
            rs = lv & ~pv;
            fl = ~lv & pv;
            for (int i = 0; i < 2; i++) begin
                exp_v[i] = 0;
                if (rs) begin
                    if (meas[i] && fseen[i]) begin
                        exp_v[i] = 1;
                        t = ticks(r1[i], fc[i], d);
                        exp_h[i] = (t > max_v[i]) ? max_v[i] : t;
                        exp_p[i] = ticks(r1[i], cyc_n, d);
                    end
                    meas[i] = 1; fseen[i] = 0; r1[i] = cyc_n; exp_s[i] = 0;
                end else if (meas[i]) begin
                    if (tk && ticks(r1[i], cyc_n, d) >= max_v[i]) begin
                        exp_s[i] = 1; exp_sl[i] = lv; meas[i] = 0;
                    end else if (fl) begin
                        fseen[i] = 1; fc[i] = cyc_n;
                    end
                end
            end
            samp_q.push_back(pwm_in);
            cyc_n++;
        end
    end

    // Driver tasks: inputs change 1 time unit after a rising edge.
    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lvl, input int k);
        pwm_in = lvl;
        cyc(k);
    endtask

    task automatic start_group(input int d);
        rst = 1'b1;
        pwm_in = 1'b0;
        divisor = 6'(d);
        cyc(2);
        rst = 1'b0;
    endtask

    typedef struct {
        int lead;
        int hi;
        int lo;
        int div;
        int reps;
        int exp_hi;
        int exp_per;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        tbl[0] = '{0, 30, 70, 0, 4, 30, 100};
        tbl[1] = '{0, 32, 96, 3, 3, 8, 32};
        tbl[2] = '{1, 32, 96, 3, 3, 8, 32};
        tbl[3] = '{2, 32, 96, 3, 3, 8, 32};
        tbl[4] = '{3, 32, 96, 3, 3, 8, 32};
        tbl[5] = '{0, 1, 99, 0, 4, 1, 100};
        tbl[6] = '{0, 99, 1, 0, 4, 99, 100};
        tbl[7] = '{0, 10, 20, 1, 4, 5, 15};

        cyc(3);

        // Table-driven periodic waveforms
        for (int v = 0; v < 8; v++) begin
            start_group(tbl[v].div);
            drive(1'b0, tbl[v].lead);
            for (int r = 0; r < tbl[v].reps; r++) begin
                drive(1'b1, tbl[v].hi);
                drive(1'b0, tbl[v].lo);
            end
            drive(1'b1, 5);
            chk($sformatf("tbl%0d_valid_count", v), val_cnt16, tbl[v].reps);
            chk($sformatf("tbl%0d_high16", v), hi16, tbl[v].exp_hi);
            chk($sformatf("tbl%0d_period16", v), per16, tbl[v].exp_per);
            chk($sformatf("tbl%0d_high8", v), hi8, tbl[v].exp_hi);
            chk($sformatf("tbl%0d_period8", v), per8, tbl[v].exp_per);
            chk($sformatf("tbl%0d_stuck16", v), stk16, 0);
        end

        // Latency: no valid on the first rise, valid exactly after edge k+2
        start_group(0);
        drive(1'b0, 3);
        drive(1'b1, 50);
        drive(1'b0, 50);
        chk("lat_no_valid_first_rise", val_cnt16, 0);
        pwm_in = 1'b1;
        @(posedge clk);
        @(negedge clk); chk("lat_k", val16, 0);
        @(posedge clk);
        @(negedge clk); chk("lat_k1", val16, 0);
        @(posedge clk);
        @(negedge clk); chk("lat_k2", val16, 1);
        chk("lat_period", per16, 100);
        chk("lat_high", hi16, 50);
        @(posedge clk);
        @(negedge clk); chk("lat_k3", val16, 0);
        @(posedge clk); #1;

        // Stuck high on the 8-bit instance, then stuck low
        start_group(0);
        for (int r = 0; r < 2; r++) begin
            drive(1'b1, 30);
            drive(1'b0, 70);
        end
        drive(1'b1, 300);
        chk("stuck_hi_set8", stk8, 1);
        chk("stuck_hi_level8", stl8, 1);
        chk("stuck_hi_hold_high8", hi8, 30);
        chk("stuck_hi_hold_period8", per8, 100);
        chk("stuck_hi_none16", stk16, 0);
        drive(1'b0, 10);
        drive(1'b1, 5);
        chk("stuck_clear8", stk8, 0);
        drive(1'b1, 20);
        drive(1'b0, 300);
        chk("stuck_lo_set8", stk8, 1);
        chk("stuck_lo_level8", stl8, 0);
        chk("stuck_lo_hold_high8", hi8, 30);
        drive(1'b1, 5);
        chk("stuck_lo_clear8", stk8, 0);
        chk("stuck_lo_level_hold8", stl8, 0);

        // Reset in the middle of a high phase
        start_group(0);
        drive(1'b1, 30);
        drive(1'b0, 70);
        drive(1'b1, 30);
        drive(1'b0, 70);
        drive(1'b1, 10);
        rst = 1'b1;
        #1;
        chk("rst_async_high16", hi16, 0);
        chk("rst_async_period16", per16, 0);
        chk("rst_async_high8", hi8, 0);
        chk("rst_async_valid16", val16, 0);
        pwm_in = 1'b0;
        cyc(2);
        rst = 1'b0;
        drive(1'b0, 5);
        drive(1'b1, 30);
        drive(1'b0, 70);
        chk("rst_no_valid_after_one_rise", val_cnt16, 0);
        drive(1'b1, 5);
        chk("rst_valid_after_two_rises", val_cnt16, 1);

        // Randomized waveforms checked by the reference model
        for (int g = 0; g < 6; g++) begin
            start_group($urandom_range(0, 4));
            drive(1'b0, $urandom_range(0, 5));
            for (int p = 0; p < 16; p++) begin
                if ($urandom_range(0, 7) == 0) begin
                    drive(1'($urandom_range(0, 1)), $urandom_range(260, 400));
                end
                drive(1'b1, $urandom_range(1, 60));
                drive(1'b0, $urandom_range(1, 60));
            end
            drive(1'b1, 5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
